// File: rtl/chip8_pkg.sv
// Shared CHIP-8 definitions: memory geometry, default program base and loader states.
package chip8_pkg;

    localparam int          MEM_DEPTH         = 4096;
    localparam logic [11:0] DEFAULT_LOAD_BASE = 12'h200;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LEN_HI,
        LEN_LO,
        LOAD,
        DONE,
        ERR
    } load_state_t;

endpackage

// File: rtl/prog_loader.sv
// Program loader: optionally zero-fills the program area, then streams a
// length-prefixed byte image into program RAM while holding the CPU stalled.
module prog_loader
    import chip8_pkg::*;
#(
    parameter logic [11:0] LOAD_BASE = DEFAULT_LOAD_BASE,
    parameter bit          CLEAR_EN  = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_we,
    output logic [11:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam logic [15:0] MAX_LEN = 16'(MEM_DEPTH - int'(LOAD_BASE));

    load_state_t state;
    logic [12:0] addr;
    logic [15:0] length;
    logic [15:0] count;
    logic [15:0] len_cand;
    logic        accept;

    // Status flags are pure decodes of the state register.
    assign in_ready = (state == LEN_HI) || (state == LEN_LO) || (state == LOAD);
    assign busy     = (state == CLEAR) || in_ready;
    assign cpu_hold = (state != DONE) && (state != ERR);
    assign done     = (state == DONE);
    assign error    = (state == ERR);
    assign accept   = in_valid && in_ready;
    assign len_cand = {length[15:8], in_data};

    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create ordering races.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            addr      <= '0;
            length    <= '0;
            count     <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        addr   <= {1'b0, LOAD_BASE};
                        length <= '0;
                        count  <= '0;
                        state  <= CLEAR_EN ? CLEAR : LEN_HI;
                    end
                end
                CLEAR: begin
                    mem_we    <= 1'b1;
                    mem_addr  <= addr[11:0];
                    mem_wdata <= 8'h00;
                    addr      <= addr + 13'd1;
                    if (addr == 13'h0FFF) state <= LEN_HI;
                end
                LEN_HI: begin
                    if (accept) begin
                        length[15:8] <= in_data;
                        state        <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (accept) begin
                        length[7:0] <= in_data;
                        addr        <= {1'b0, LOAD_BASE};
                        count       <= '0;
                        // Reject empty images and images that would run past the top of RAM.
                        if (len_cand == 16'd0 || len_cand > MAX_LEN) state <= ERR;
                        else                                          state <= LOAD;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= addr[11:0];
                        mem_wdata <= in_data;
                        addr      <= addr + 13'd1;
                        count     <= count + 16'd1;
                        if (count == length - 16'd1) state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: one instance without and one with zero-fill.
module tb_prog_loader;
    import chip8_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start0 = 1'b0, v0 = 1'b0;
    logic [7:0]  d0 = 8'h00;
    logic        start1 = 1'b0;
    logic        rdy0, we0, hold0, busy0, done0, err0;
    logic [11:0] addr0;
    logic [7:0]  wdata0;
    logic        rdy1, we1, hold1, busy1, done1, err1;
    logic [11:0] addr1;
    logic [7:0]  wdata1;

    int n_cmp = 0;
    int n_bad = 0;
    logic [11:0] log_addr[$];
    logic [7:0]  log_data[$];

    always #5 clk = ~clk;

    prog_loader #(.CLEAR_EN(1'b0)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .in_valid(v0), .in_data(d0),
        .in_ready(rdy0), .mem_we(we0), .mem_addr(addr0), .mem_wdata(wdata0),
        .cpu_hold(hold0), .busy(busy0), .done(done0), .error(err0)
    );

    prog_loader #(.CLEAR_EN(1'b1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .in_valid(1'b0), .in_data(8'h00),
        .in_ready(rdy1), .mem_we(we1), .mem_addr(addr1), .mem_wdata(wdata1),
        .cpu_hold(hold1), .busy(busy1), .done(done1), .error(err1)
    );

    always @(negedge clk) begin
        if (we0) begin
            log_addr.push_back(addr0);
            log_data.push_back(wdata0);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start0();
        @(negedge clk) start0 = 1'b1;
        @(negedge clk) start0 = 1'b0;
    endtask

    task automatic send0(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        v0 = 1'b1;
        d0 = b;
        while (!rdy0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!rdy0) check("send_timeout", rdy0, 1);
        @(posedge clk);
        #1 v0 = 1'b0;
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, rdy0, 0);
        check({tag, "_mem_we"},   we0,  0);
        check({tag, "_mem_addr"}, addr0, 0);
        check({tag, "_wdata"},    wdata0, 0);
        check({tag, "_busy"},     busy0, 0);
        check({tag, "_done"},     done0, 0);
        check({tag, "_error"},    err0, 0);
        check({tag, "_cpu_hold"}, hold0, 1);
    endtask

    initial begin
        logic [7:0] exp_data[16];
        int nz, bad_addr, bad_data, early_ready, cyc;

        // Reset state
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_hold", hold0, 1);

        // Basic three-byte program
        clear_log();
        pulse_start0();
        check("t1_busy", busy0, 1);
        check("t1_ready", rdy0, 1);
        send0(8'h00); send0(8'h03); send0(8'hA2); send0(8'h2A); send0(8'h60);
        repeat (2) @(negedge clk);
        check("t1_nwr", log_addr.size(), 3);
        if (log_addr.size() == 3) begin
            check("t1_a0", log_addr[0], 12'h200); check("t1_d0", log_data[0], 8'hA2);
            check("t1_a1", log_addr[1], 12'h201); check("t1_d1", log_data[1], 8'h2A);
            check("t1_a2", log_addr[2], 12'h202); check("t1_d2", log_data[2], 8'h60);
        end
        check("t1_done", done0, 1);
        check("t1_hold", hold0, 0);
        check("t1_busy_end", busy0, 0);
        check("t1_ready_end", rdy0, 0);

        // Start during LOAD is ignored; start in DONE begins a new load
        clear_log();
        pulse_start0();
        check("t2_done_cleared", done0, 0);
        send0(8'h00); send0(8'h04); send0(8'h11);
        pulse_start0();
        send0(8'h22); send0(8'h33); send0(8'h44);
        repeat (2) @(negedge clk);
        check("t2_nwr", log_addr.size(), 4);
        if (log_addr.size() == 4) begin
            check("t2_a3", log_addr[3], 12'h203); check("t2_d3", log_data[3], 8'h44);
            check("t2_d1", log_data[1], 8'h22);
        end
        check("t2_done", done0, 1);
        clear_log();
        pulse_start0();
        check("t2_restart_done", done0, 0);
        check("t2_restart_busy", busy0, 1);
        check("t2_restart_hold", hold0, 1);
        send0(8'h00); send0(8'h01); send0(8'h55);
        repeat (2) @(negedge clk);
        check("t2b_nwr", log_addr.size(), 1);
        if (log_addr.size() == 1) begin
            check("t2b_a0", log_addr[0], 12'h200); check("t2b_d0", log_data[0], 8'h55);
        end
        check("t2b_done", done0, 1);

        // Length one past the limit, and zero length, are rejected
        clear_log();
        pulse_start0();
        send0(8'h0E); send0(8'h01);
        repeat (3) @(negedge clk);
        check("t3_err", err0, 1);
        check("t3_done", done0, 0);
        check("t3_ready", rdy0, 0);
        check("t3_hold", hold0, 0);
        check("t3_nwr", log_addr.size(), 0);
        pulse_start0();
        check("t3_err_cleared", err0, 0);
        send0(8'h00); send0(8'h00);
        repeat (2) @(negedge clk);
        check("t3_zero_err", err0, 1);
        check("t3_zero_nwr", log_addr.size(), 0);
        // Exactly the limit (3584) is accepted
        pulse_start0();
        send0(8'h0E); send0(8'h00);
        @(negedge clk);
        check("t3_max_err", err0, 0);
        check("t3_max_ready", rdy0, 1);

        // Reset mid-load, then a fresh two-byte load
        reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        clear_log();
        pulse_start0();
        send0(8'h00); send0(8'h0A);
        for (int i = 0; i < 5; i++) send0(8'(8'h90 + i));
        #2 reset = 1'b1;
        #1 check_reset_outputs("midrst");
        @(negedge clk) reset = 1'b0;
        clear_log();
        repeat (3) @(negedge clk);
        check("t4_nowr", log_addr.size(), 0);
        check("t4_hold_idle", hold0, 1);
        pulse_start0();
        send0(8'h00); send0(8'h02); send0(8'hC1); send0(8'hC2);
        repeat (2) @(negedge clk);
        check("t4_nwr", log_addr.size(), 2);
        if (log_addr.size() == 2) begin
            check("t4_a0", log_addr[0], 12'h200); check("t4_d0", log_data[0], 8'hC1);
            check("t4_a1", log_addr[1], 12'h201); check("t4_d1", log_data[1], 8'hC2);
        end
        check("t4_done", done0, 1);

        // 16-byte load with in_valid gaps
        clear_log();
        pulse_start0();
        send0(8'h00); send0(8'h10);
        for (int i = 0; i < 16; i++) begin
            exp_data[i] = 8'(i * 17 + 3);
            repeat ((i * 7) % 3) @(negedge clk);
            send0(exp_data[i]);
        end
        repeat (2) @(negedge clk);
        check("t5_nwr", log_addr.size(), 16);
        if (log_addr.size() == 16) begin
            for (int i = 0; i < 16; i++) begin
                check($sformatf("t5_a%0d", i), log_addr[i], 12'(12'h200 + i));
                check($sformatf("t5_d%0d", i), log_data[i], exp_data[i]);
            end
        end
        check("t5_done", done0, 1);

        // Zero-fill on the CLEAR_EN=1 instance
        @(negedge clk) start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
        nz = 0; bad_addr = 0; bad_data = 0; early_ready = 0; cyc = 0;
        check("t6_busy", busy1, 1);
        check("t6_hold", hold1, 1);
        while (!rdy1 && cyc < 5000) begin
            if (we1) begin
                if (addr1 != 12'(12'h200 + nz)) bad_addr++;
                if (wdata1 != 8'h00) bad_data++;
                nz++;
            end
            @(negedge clk);
            cyc++;
        end
        if (we1) begin
            if (addr1 != 12'(12'h200 + nz)) bad_addr++;
            if (wdata1 != 8'h00) bad_data++;
            nz++;
        end
        if (rdy1 && nz < 3584) early_ready++;
        check("t6_nzero", nz, 3584);
        check("t6_bad_addr", bad_addr, 0);
        check("t6_bad_data", bad_data, 0);
        check("t6_early_ready", early_ready, 0);
        check("t6_ready", rdy1, 1);
        @(negedge clk);
        check("t6_we_after", we1, 0);
        check("t6_busy_after", busy1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
